// File: rtl/up_memory_pkg.sv
// Shared FSM state type and boot image for up_memory_ctrl.
// The image is only loaded when UP_MEMORY_BOOT_EN is defined.
package up_memory_pkg;

    typedef enum logic [0:0] {
        StInit,
        StReady
    } state_e;

    localparam int unsigned BOOT_LEN = 14;

    localparam logic [7:0] BOOT_IMAGE [BOOT_LEN] = '{
        8'h08, 8'h02, 8'h03, 8'h04, 8'h01, 8'h23, 8'hE4,
        8'h5B, 8'hBB, 8'hBA, 8'h6A, 8'h54, 8'hA5, 8'hA7
    };

    function automatic logic [7:0] boot_byte(input int unsigned idx);
        logic [7:0] val;
        val = 8'h00;
        if (idx < BOOT_LEN) begin
            val = BOOT_IMAGE[idx[3:0]];
        end
        return val;
    endfunction

endpackage

// File: rtl/up_memory_boot_rom.sv
// Combinational boot ROM: maps the init pointer to a boot word of DATA_W bits
// (zero-extended or truncated), returning zero past the end of the image.
module up_memory_boot_rom
    import up_memory_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] ptr_i,
    output logic [DATA_W-1:0] word_o
);

    logic [7:0] boot_val;

    always_comb begin
        boot_val = boot_byte(32'(ptr_i));
        word_o   = DATA_W'(boot_val);
    end

endmodule

// File: rtl/up_memory_ctrl.sv
// Data/program memory with registered read port, valid strobe and a post-reset init engine.
// Define UP_MEMORY_BOOT_EN to load the boot image during init; otherwise init writes zeros.
module up_memory_ctrl
    import up_memory_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [DATA_W-1:0] in_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              we_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] out_o,
    output logic              valid_o,
    output logic              re_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              valid_q, valid_d;

    // No reset on the array: the init engine rewrites every word after reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] init_word;
    logic              in_range;
    logic [IDX_W-1:0]  addr_idx;

    assign in_range = (32'(address_i) < DEPTH);
    assign addr_idx = address_i[IDX_W-1:0];

`ifdef UP_MEMORY_BOOT_EN
    up_memory_boot_rom #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_boot_rom (
        .ptr_i (ADDR_W'(ptr_q)),
        .word_o(init_word)
    );
`else
    assign init_word = '0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = init_word;
        case (state_q)
            StInit: begin
                mem_we = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = StReady;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            StReady: begin
                if (we_i && in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr_idx;
                    mem_wdata = in_i;
                end
                if (rd_i) begin
                    valid_d = 1'b1;
                    // Single address port: a combined write+read always hits the same word.
                    if (!in_range) begin
                        out_d = '0;
                    end else if (we_i) begin
                        out_d = in_i;
                    end else begin
                        out_d = mem_q[addr_idx];
                    end
                end
            end
            default: begin
                state_d = StInit;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= StInit;
            ptr_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign out_o   = out_q;
    assign valid_o = valid_q;
    assign re_o    = (state_q == StReady);

endmodule

// File: tb/tb_up_memory_ctrl.sv
// Directed bench for up_memory_ctrl (default 256-word instance plus a 16-word instance).
module tb_up_memory_ctrl;

`ifdef UP_MEMORY_BOOT_EN
    localparam logic [7:0] BOOT [14] = '{
        8'h08, 8'h02, 8'h03, 8'h04, 8'h01, 8'h23, 8'hE4,
        8'h5B, 8'hBB, 8'hBA, 8'h6A, 8'h54, 8'hA5, 8'hA7
    };
`else
    localparam logic [7:0] BOOT [14] = '{default: 8'h00};
`endif

    logic       clk = 1'b0;
    logic       nRst = 1'b1;
    logic [7:0] din, addr, out;
    logic       we, rd, valid, re;
    logic [7:0] din16, addr16, out16;
    logic       we16, rd16, valid16, re16;

    int checks = 0;
    int errors = 0;
    bit saw_valid;

    always #5 clk = ~clk;

    up_memory_ctrl dut (
        .clk      (clk),
        .nRst     (nRst),
        .in_i     (din),
        .address_i(addr),
        .we_i     (we),
        .rd_i     (rd),
        .out_o    (out),
        .valid_o  (valid),
        .re_o     (re)
    );

    up_memory_ctrl #(
        .DATA_W(8),
        .ADDR_W(8),
        .DEPTH (16)
    ) dut16 (
        .clk      (clk),
        .nRst     (nRst),
        .in_i     (din16),
        .address_i(addr16),
        .we_i     (we16),
        .rd_i     (rd16),
        .out_o    (out16),
        .valid_o  (valid16),
        .re_o     (re16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        we = w; rd = r; addr = a; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step16(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        we16 = w; rd16 = r; addr16 = a; din16 = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        we = 1'b0; rd = 1'b0; addr = '0; din = '0;
        we16 = 1'b0; rd16 = 1'b0; addr16 = '0; din16 = '0;

        #2 nRst = 1'b0;
        #1;
        chk("reset_out", out, 8'h00);
        chk("reset_valid", valid, 1'b0);
        chk("reset_re", re, 1'b0);

        // Requests held throughout init must be ignored.
        we = 1'b1; rd = 1'b1; addr = 8'd5; din = 8'hFF;
        @(negedge clk) nRst = 1'b1;
        saw_valid = 1'b0;
        repeat (255) begin
            @(posedge clk);
            #1;
            if (valid) saw_valid = 1'b1;
        end
        chk("re_low_edge255", re, 1'b0);
        @(posedge clk);
        #1;
        if (valid) saw_valid = 1'b1;
        chk("re_high_edge256", re, 1'b1);
        chk("no_valid_in_init", saw_valid, 1'b0);
        we = 1'b0; rd = 1'b0;
        chk("dut16_ready", re16, 1'b1);

        step(1'b0, 1'b1, 8'd5, 8'h00);
        chk("init_ignores_write_out", out, BOOT[5]);
        chk("init_ignores_write_valid", valid, 1'b1);
        step(1'b0, 1'b1, 8'd200, 8'h00);
        chk("read_200", out, 8'h00);

        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b1, 8'(i), 8'h00);
            chk($sformatf("boot_%0d", i), out, BOOT[4'(i)]);
            chk($sformatf("boot_valid_%0d", i), valid, 1'b1);
        end

        step(1'b0, 1'b0, 8'd0, 8'h00);
        chk("idle_valid", valid, 1'b0);
        chk("idle_out_hold", out, BOOT[13]);

        step(1'b1, 1'b0, 8'h40, 8'hAA);
        chk("write_no_valid", valid, 1'b0);
        step(1'b0, 1'b1, 8'h40, 8'h00);
        chk("wr_rd_out", out, 8'hAA);
        chk("wr_rd_valid", valid, 1'b1);

        step(1'b1, 1'b1, 8'd3, 8'h77);
        chk("bypass_out", out, 8'h77);
        chk("bypass_valid", valid, 1'b1);
        step(1'b0, 1'b1, 8'd3, 8'h00);
        chk("bypass_stored", out, 8'h77);
        step(1'b0, 1'b0, 8'd0, 8'h00);

        // 16-word instance: out-of-range behaviour and no aliasing of high addresses.
        step16(1'b1, 1'b0, 8'h20, 8'h55);
        step16(1'b0, 1'b1, 8'h20, 8'h00);
        chk("oor_read_out", out16, 8'h00);
        chk("oor_read_valid", valid16, 1'b1);
        step16(1'b0, 1'b1, 8'h00, 8'h00);
        chk("oor_no_alias", out16, BOOT[0]);
        step16(1'b0, 1'b1, 8'h0D, 8'h00);
        chk("d16_boot_13", out16, BOOT[13]);
        step16(1'b1, 1'b0, 8'h02, 8'h3C);
        step16(1'b0, 1'b1, 8'h02, 8'h00);
        chk("d16_write_read", out16, 8'h3C);
        step16(1'b1, 1'b1, 8'h30, 8'h99);
        chk("oor_bypass_out", out16, 8'h00);
        step16(1'b0, 1'b0, 8'h00, 8'h00);

        // Reset mid-READY, then again mid-INIT at ptr=100.
        nRst = 1'b0;
        #1;
        chk("rst2_re", re, 1'b0);
        chk("rst2_out", out, 8'h00);
        chk("rst2_valid", valid16, 1'b0);
        @(negedge clk) nRst = 1'b1;
        repeat (100) @(posedge clk);
        #1 nRst = 1'b0;
        #1;
        chk("rst3_re", re, 1'b0);
        @(negedge clk) nRst = 1'b1;
        repeat (255) @(posedge clk);
        #1;
        chk("rst3_re_edge255", re, 1'b0);
        @(posedge clk);
        #1;
        chk("rst3_re_edge256", re, 1'b1);
        step(1'b0, 1'b1, 8'd0, 8'h00);
        chk("rst3_addr0", out, BOOT[0]);
        step(1'b0, 1'b1, 8'h40, 8'h00);
        chk("rst3_reinit_40", out, 8'h00);
        step(1'b0, 1'b0, 8'd0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
